// File: rtl/capture_pkg.sv
// Types and constants shared by the capture controller and the trigger block.
package capture_pkg;

    localparam int SAMPLE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PRETRIG,
        WAIT_TRIG,
        POSTTRIG,
        DONE
    } cap_state_t;

    // States in which a valid sample is written to the RAM.
    function automatic logic is_capturing(input cap_state_t s);
        return s inside {PRETRIG, WAIT_TRIG, POSTTRIG};
    endfunction

endpackage

// File: rtl/capture_controller_wrap_counter.sv
// Enable/clear counter that wraps DEPTH-1 -> 0; used for the write pointer and sample count.
module wrap_counter #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    output logic [ADDR_WIDTH-1:0] count
);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= (count == ADDR_WIDTH'(DEPTH - 1)) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: arms the trigger, fills the circular sample RAM, reports trigger/start addresses.
module capture_controller #(
    parameter int SAMPLE_WIDTH = capture_pkg::SAMPLE_WIDTH,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = $clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    valid,
    input  logic [SAMPLE_WIDTH-1:0] dataIn,
    input  logic [ADDR_WIDTH-1:0]   preTrig,
    input  logic [ADDR_WIDTH-1:0]   postTrig,
    input  logic                    run,
    output logic                    arm,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [SAMPLE_WIDTH-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   trig_addr,
    output logic [ADDR_WIDTH-1:0]   start_addr
);

    import capture_pkg::*;

    cap_state_t            state;
    cap_state_t            next_state;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] post_q;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] count;
    logic                  accept_start;
    logic                  write;
    logic                  trigger;
    logic                  count_clear;
    logic                  count_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        write        = 1'b0;
        trigger      = 1'b0;
        if (abort) begin
            // Abort wins over start and run and also blocks the write in this cycle.
            next_state = IDLE;
        end else begin
            write = is_capturing(state) && valid;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        accept_start = 1'b1;
                        next_state   = ARM;
                    end
                end
                ARM: begin
                    next_state = (pre_q == '0) ? WAIT_TRIG : PRETRIG;
                end
                PRETRIG: begin
                    if (valid && (count == pre_q - 1'b1)) begin
                        next_state = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (valid && run) begin
                        trigger    = 1'b1;
                        next_state = (post_q == '0) ? DONE : POSTTRIG;
                    end
                end
                POSTTRIG: begin
                    if (valid && (count == post_q - 1'b1)) begin
                        next_state = DONE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // The sample count restarts on every state change, so each phase counts from zero.
    assign count_clear = (next_state != state);
    assign count_en    = write && (state inside {PRETRIG, POSTTRIG});

    wrap_counter #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ptr (
        .clock (clock),
        .reset (reset),
        .clear (accept_start),
        .en    (write),
        .count (ptr)
    );

    wrap_counter #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_count (
        .clock (clock),
        .reset (reset),
        .clear (count_clear),
        .en    (count_en),
        .count (count)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q      <= '0;
            post_q     <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
        end else begin
            if (accept_start) begin
                pre_q  <= preTrig;
                post_q <= postTrig;
            end
            if (trigger) begin
                trig_addr  <= ptr;
                start_addr <= ptr - pre_q;
            end
        end
    end

    assign arm     = (state == ARM);
    assign busy    = state inside {ARM, PRETRIG, WAIT_TRIG, POSTTRIG};
    assign done    = (state == DONE);
    assign wr_en   = write;
    assign wr_addr = ptr;
    assign wr_data = dataIn;

endmodule

// File: tb/tb_capture_controller.sv
// Self-checking bench for capture_controller at DEPTH = 16 with a write scoreboard.
module tb_capture_controller;

    import capture_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int SW    = 8;

    logic          clock;
    logic          reset;
    logic          start;
    logic          abort;
    logic          valid;
    logic          run;
    logic [SW-1:0] dataIn;
    logic [SW-1:0] wr_data;
    logic [AW-1:0] preTrig;
    logic [AW-1:0] postTrig;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;
    logic          arm;
    logic          wr_en;
    logic          busy;
    logic          done;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] value;
    } wr_t;

    typedef struct {
        int pre;
        int post;
        int n_wait;
        bit toggle;
        bit run_early;
        int exp_trig;
        int exp_start;
    } vec_t;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            tests     = 0;
    int            failed    = 0;
    int            wr_count  = 0;
    int            arm_count = 0;
    logic [AW-1:0] ptr;
    logic [SW-1:0] smp;

    capture_controller #(
        .SAMPLE_WIDTH (SW),
        .DEPTH        (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .valid      (valid),
        .dataIn     (dataIn),
        .preTrig    (preTrig),
        .postTrig   (postTrig),
        .run        (run),
        .arm        (arm),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .trig_addr  (trig_addr),
        .start_addr (start_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: run still active at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every RAM write must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (arm === 1'b1) arm_count++;
        if (wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL spurious_wr_en: write at addr %0d data %0h, none expected", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb.wr_addr", 32'(wr_addr), 32'(mon_e.addr));
                check("sb.wr_data", 32'(wr_data), 32'(mon_e.value));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One capture-phase cycle; queues the expected write when the sample should land.
    task automatic drive(input bit v, input bit r, input bit expect_wr);
        valid  = v;
        run    = r;
        dataIn = smp;
        if (v && expect_wr) begin
            exp_q.push_back('{addr: ptr, value: smp});
            ptr = ptr + 1'b1;
        end
        smp = smp + 1'b1;
        step();
    endtask

    task automatic run_capture(input vec_t t, input string tag);
        int k;
        int n;
        int wr_base;
        int arm_base;
        bit v;
        bit trig;
        k        = 0;
        wr_base  = wr_count;
        arm_base = arm_count;
        preTrig  = AW'(t.pre);
        postTrig = AW'(t.post);
        start    = 1'b1;
        valid    = 1'b0;
        run      = 1'b0;
        @(negedge clock);
        check($sformatf("%s.start_cycle_arm", tag), 32'(arm), 0);
        step();
        // Scramble the config inputs to show they were latched at start.
        start    = 1'b0;
        preTrig  = '1;
        postTrig = '1;
        valid    = 1'b1;
        run      = t.run_early;
        dataIn   = 8'hEE;
        @(negedge clock);
        check($sformatf("%s.arm_pulse", tag), 32'(arm), 1);
        check($sformatf("%s.arm_busy", tag), 32'(busy), 1);
        check($sformatf("%s.arm_no_write", tag), 32'(wr_en), 0);
        step();
        ptr = '0;
        n = 0;
        while (n < t.pre) begin
            v = !t.toggle || (k % 2 == 0);
            drive(v, t.run_early, 1'b1);
            k++;
            if (v) n++;
        end
        n = 0;
        while (1) begin
            v    = !t.toggle || (k % 2 == 0);
            trig = v && (n == t.n_wait);
            drive(v, t.run_early || trig || (t.toggle && !v), 1'b1);
            k++;
            if (trig) break;
            if (v) n++;
        end
        n = 0;
        while (n < t.post) begin
            v = !t.toggle || (k % 2 == 0);
            drive(v, t.run_early, 1'b1);
            k++;
            if (v) n++;
        end
        valid  = 1'b1;
        run    = 1'b1;
        dataIn = smp;
        @(negedge clock);
        check($sformatf("%s.done", tag), 32'(done), 1);
        check($sformatf("%s.done_busy", tag), 32'(busy), 0);
        check($sformatf("%s.done_no_write", tag), 32'(wr_en), 0);
        check($sformatf("%s.trig_addr", tag), 32'(trig_addr), 32'(t.exp_trig));
        check($sformatf("%s.start_addr", tag), 32'(start_addr), 32'(t.exp_start));
        check($sformatf("%s.pending_writes", tag), 32'(exp_q.size()), 0);
        check($sformatf("%s.write_count", tag), 32'(wr_count - wr_base), 32'(t.pre + t.n_wait + 1 + t.post));
        check($sformatf("%s.arm_count", tag), 32'(arm_count - arm_base), 1);
        step();
        valid = 1'b0;
        run   = 1'b0;
    endtask

    initial begin
        vec_t vecs[6];
        ptr      = '0;
        smp      = 8'h10;
        reset    = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        valid    = 1'b0;
        run      = 1'b0;
        dataIn   = '0;
        preTrig  = '0;
        postTrig = '0;

        vecs[0] = '{pre: 4,  post: 3, n_wait: 6,  toggle: 1'b0, run_early: 1'b0, exp_trig: 10, exp_start: 6};
        vecs[1] = '{pre: 5,  post: 2, n_wait: 0,  toggle: 1'b0, run_early: 1'b1, exp_trig: 5,  exp_start: 0};
        vecs[2] = '{pre: 2,  post: 4, n_wait: 13, toggle: 1'b1, run_early: 1'b0, exp_trig: 15, exp_start: 13};
        vecs[3] = '{pre: 0,  post: 0, n_wait: 0,  toggle: 1'b0, run_early: 1'b0, exp_trig: 0,  exp_start: 0};
        vecs[4] = '{pre: 3,  post: 2, n_wait: 0,  toggle: 1'b0, run_early: 1'b0, exp_trig: 3,  exp_start: 0};
        vecs[5] = '{pre: 12, post: 6, n_wait: 0,  toggle: 1'b0, run_early: 1'b0, exp_trig: 12, exp_start: 0};

        // Reset held for three cycles with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst.arm", 32'(arm), 0);
            check("rst.busy", 32'(busy), 0);
            check("rst.done", 32'(done), 0);
            check("rst.wr_en", 32'(wr_en), 0);
        end
        check("rst.wr_addr", 32'(wr_addr), 0);
        check("rst.trig_addr", 32'(trig_addr), 0);
        check("rst.start_addr", 32'(start_addr), 0);
        check("rst.state", 32'(dut.state), 32'(IDLE));
        step();
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_release.arm", 32'(arm), 0);
        end
        step();

        for (int i = 0; i < 6; i++) begin
            run_capture(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort in POSTTRIG; a start during PRETRIG must be ignored on the way.
        preTrig  = 4'd2;
        postTrig = 4'd5;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        ptr     = '0;
        start   = 1'b1;
        preTrig = 4'd7;
        drive(1'b1, 1'b0, 1'b1);
        start = 1'b0;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        abort  = 1'b1;
        start  = 1'b1;
        valid  = 1'b1;
        run    = 1'b1;
        dataIn = smp;
        @(negedge clock);
        check("abort.cycle_wr_en", 32'(wr_en), 0);
        check("abort.cycle_busy", 32'(busy), 1);
        step();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("abort.state", 32'(dut.state), 32'(IDLE));
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        check("abort.idle_wr_en", 32'(wr_en), 0);
        check("abort.trig_addr_held", 32'(trig_addr), 3);
        check("abort.start_addr_held", 32'(start_addr), 1);
        check("abort.pending_writes", 32'(exp_q.size()), 0);
        step();
        valid = 1'b0;
        run   = 1'b0;
        run_capture(vecs[0], "post_abort");

        // Reset while waiting for the trigger.
        preTrig  = 4'd1;
        postTrig = 4'd2;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        ptr = '0;
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        valid = 1'b0;
        run   = 1'b1;
        @(negedge clock);
        check("mid_rst.before_busy", 32'(busy), 1);
        step();
        @(negedge clock);
        check("mid_rst.state", 32'(dut.state), 32'(IDLE));
        check("mid_rst.busy", 32'(busy), 0);
        check("mid_rst.done", 32'(done), 0);
        check("mid_rst.wr_addr", 32'(wr_addr), 0);
        check("mid_rst.trig_addr", 32'(trig_addr), 0);
        check("mid_rst.start_addr", 32'(start_addr), 0);
        step();
        reset = 1'b0;
        run   = 1'b0;
        @(negedge clock);
        check("mid_rst.release_arm", 32'(arm), 0);
        check("mid_rst.release_state", 32'(dut.state), 32'(IDLE));
        check("mid_rst.pending_writes", 32'(exp_q.size()), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Consumer end of the trigger arm/run handshake.
- On a host start it pulses `arm` to the trigger and streams valid samples into a circular sample RAM. It guarantees `preTrig` samples before accepting `run`, then writes `postTrig` further samples and reports completion.
- Sits between the host command decoder, the trigger block and the dual-port sample RAM.

Parameters:
- SAMPLE_WIDTH, 8, channels per sample; must match the trigger block.
- DEPTH, 1024, sample RAM words; power of two, >= 4.
- ADDR_WIDTH, $clog2(DEPTH), RAM address and count width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle host command; begin capture; honoured in IDLE or DONE only.
- abort  in  1  host command; return to IDLE next cycle from any state.
- valid  in  1  dataIn qualifier.
- dataIn  in  SAMPLE_WIDTH  sample word.
- preTrig  in  ADDR_WIDTH  samples to hold before trigger; latched at start.
- postTrig  in  ADDR_WIDTH  samples after the trigger sample; latched at start.
- run  in  1  trigger-fired indication from the trigger block.
- arm  out  1  one-cycle pulse to the trigger block.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_WIDTH  RAM write address.
- wr_data  out  SAMPLE_WIDTH  RAM write data.
- busy  out  1  high in ARM, PRETRIG, WAIT_TRIG, POSTTRIG.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_WIDTH  address holding the trigger sample.
- start_addr  out  ADDR_WIDTH  oldest valid sample = (trig_addr - latched preTrig) mod DEPTH.

Behaviour:
- Reset:
  - state = IDLE.
  - arm, wr_en, busy, done = 0.
  - wr_addr, trig_addr, start_addr, internal counters = 0.
- Config rule: preTrig + postTrig + 1 <= DEPTH is the host's responsibility. If violated, the oldest pre-trigger samples are overwritten; no error flag is raised.
- IDLE / DONE:
  - start → ARM.
  - Latch preTrig and postTrig; clear wr_addr and the sample count.
- ARM (exactly 1 cycle):
  - arm = 1; no writes.
  - Next state is PRETRIG, or WAIT_TRIG if latched preTrig = 0.
- Writes: in PRETRIG, WAIT_TRIG and POSTTRIG, each clock with valid = 1 gives:
  - wr_en = 1 combinationally.
  - wr_data = dataIn, wr_addr = current pointer.
  - Pointer increments after the write, wrapping DEPTH-1 → 0.
  - valid = 0 means no write and no count.
- PRETRIG:
  - run is ignored.
  - Count valid writes; after the preTrig-th write, next state is WAIT_TRIG.
- WAIT_TRIG:
  - Keep writing circularly.
  - On a cycle with run = 1 and valid = 1, that sample is the trigger sample: it is written, trig_addr = its wr_addr is latched, and start_addr is computed.
  - Next state is POSTTRIG, or DONE if postTrig = 0.
  - run = 1 with valid = 0 is ignored.
- POSTTRIG:
  - Count valid writes; after the postTrig-th write, next state is DONE.
  - run is ignored.
- DONE:
  - done = 1, no writes.
  - trig_addr and start_addr are held until the next start.
- abort:
  - Has priority over start and run.
  - Next cycle: state = IDLE, busy = 0, done = 0; write-enable is suppressed in the abort cycle itself.
  - trig_addr and start_addr keep their last values.
- arm latency: start in cycle N gives arm = 1 in cycle N+1 and the first possible write in cycle N+2.
- start while busy: ignored.
- reset mid-capture: identical to the reset values above; the RAM contents are undefined to the host.

Decomposition:
- Shared package capture_pkg:
  - typedef enum cap_state_t {IDLE, ARM, PRETRIG, WAIT_TRIG, POSTTRIG, DONE}.
  - SAMPLE_WIDTH constant, shared with the trigger block.
- Sub-module wrap_counter:
  - ADDR_WIDTH-bit enable/clear counter with modulo-DEPTH wrap.
  - Instantiated for the write pointer and for the sample count.

Test Plan (DEPTH = 16):
- Reset values: assert reset for 3 cycles with start = 1 → all outputs 0, state IDLE; after release, arm stays 0 until a fresh start.
- Basic capture: preTrig = 4, postTrig = 3, valid always 1, run asserted 6 cycles after the last pre write → arm pulses once; trigger sample at trig_addr = 10; start_addr = 6; last write at addr 13; done = 1 the next cycle; exactly 14 wr_en pulses.
- Early run ignored: preTrig = 5, run held high from the arm cycle → trigger accepted on the first WAIT_TRIG valid cycle; trig_addr = 5, start_addr = 0.
- Wrap and gaps: preTrig = 2, postTrig = 4, valid toggling 1/0, trigger at pointer 15 → trig_addr = 15; post writes at 0, 1, 2, 3 only on valid cycles; start_addr = 13.
- Zero counts: preTrig = 0, postTrig = 0 → ARM then WAIT_TRIG; a single write on run & valid; done the next cycle; trig_addr = start_addr = 0.
- Abort and reset mid-capture: abort in POSTTRIG → no wr_en in the abort cycle, IDLE next, done = 0; a subsequent start captures normally. Reset in WAIT_TRIG → IDLE with reset values.
